// File: rtl/snake_body_tracker.sv
// Snake body tracker: holds segment coordinates, advances the snake on each game step,
// detects wall/self collisions and flags scanned pixels that fall on a live segment.
module snake_body_tracker #(
    parameter int unsigned MAX_LEN  = 16,
    parameter int unsigned INIT_LEN = 3,
    parameter int unsigned INIT_COL = 10,
    parameter int unsigned INIT_ROW = 12
) (
    input  logic       clk_crystal,
    input  logic       reset,
    input  logic       start,
    input  logic       step_tick,
    input  logic [1:0] dir,
    input  logic       grow,
    input  logic [9:0] pixel_x,
    input  logic [9:0] pixel_y,
    output logic       snake_region,
    output logic [4:0] head_col,
    output logic [4:0] head_row,
    output logic [4:0] length,
    output logic       dead,
    output logic       hit_pulse
);

    localparam int unsigned CW = 5;
    localparam int unsigned LW = 5;
    localparam logic [1:0] D_UP    = 2'd0;
    localparam logic [1:0] D_DOWN  = 2'd1;
    localparam logic [1:0] D_LEFT  = 2'd2;
    localparam logic [1:0] D_RIGHT = 2'd3;
    localparam logic [CW-1:0] LAST_COL   = CW'(31);
    localparam logic [CW-1:0] LAST_ROW   = CW'(23);
    localparam logic [CW-1:0] TUNNEL_ROW = CW'(12);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DEAD} state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] seg_col [MAX_LEN];
    logic [CW-1:0] seg_row [MAX_LEN];
    logic [1:0]    cur_dir;
    logic          grow_pending;

    logic [1:0]    new_dir;
    logic [CW-1:0] nxt_col, nxt_row;
    logic          wall_hit, self_hit, grows;
    logic          do_init, do_shift, do_hit;
    logic [5:0]    px_col, px_row;
    logic          px_in_range, px_match;

    assign head_col = seg_col[0];
    assign head_row = seg_row[0];

    // Candidate head for the next step, with the row-12 tunnel wrap
    always_comb begin
        new_dir = (dir == (cur_dir ^ 2'd1)) ? cur_dir : dir;
        nxt_col = seg_col[0];
        nxt_row = seg_row[0];
        case (new_dir)
            D_UP:    nxt_row = seg_row[0] - CW'(1);
            D_DOWN:  nxt_row = seg_row[0] + CW'(1);
            D_LEFT:  nxt_col = (seg_col[0] == CW'(0)) ? LAST_COL : seg_col[0] - CW'(1);
            default: nxt_col = (seg_col[0] == LAST_COL) ? CW'(0) : seg_col[0] + CW'(1);
        endcase
        wall_hit = (nxt_row == CW'(0)) || (nxt_row == LAST_ROW) ||
                   (((nxt_col == CW'(0)) || (nxt_col == LAST_COL)) && (nxt_row != TUNNEL_ROW));
    end

    // The tail only counts as an obstacle when it will not vacate this step
    always_comb begin
        grows    = (grow_pending || grow) && (length < LW'(MAX_LEN));
        self_hit = 1'b0;
        for (int i = 0; i < int'(MAX_LEN); i++) begin
            if (((LW'(i + 1) < length) || ((LW'(i + 1) == length) && grows)) &&
                (seg_col[i] == nxt_col) && (seg_row[i] == nxt_row))
                self_hit = 1'b1;
        end
    end

    always_comb begin
        state_d  = state_q;
        do_init  = 1'b0;
        do_shift = 1'b0;
        do_hit   = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_RUN;
                    do_init = 1'b1;
                end
            end
            S_RUN: begin
                if (step_tick) begin
                    if (wall_hit || self_hit) begin
                        state_d = S_DEAD;
                        do_hit  = 1'b1;
                    end else begin
                        do_shift = 1'b1;
                    end
                end
            end
            S_DEAD: begin
                if (start) begin
                    state_d = S_RUN;
                    do_init = 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_crystal) begin
        if (reset) begin
            state_q   <= S_IDLE;
            dead      <= 1'b0;
            hit_pulse <= 1'b0;
        end else begin
            state_q   <= state_d;
            dead      <= (state_d == S_DEAD);
            hit_pulse <= do_hit;
        end
    end

    // Body storage: reinitialise, shift on a clean step, or latch a grow request
    always_ff @(posedge clk_crystal) begin
        if (reset || do_init) begin
            for (int i = 0; i < int'(MAX_LEN); i++) begin
                seg_col[i] <= CW'(INIT_COL - i);
                seg_row[i] <= CW'(INIT_ROW);
            end
            length       <= LW'(INIT_LEN);
            cur_dir      <= D_RIGHT;
            grow_pending <= 1'b0;
        end else if (do_shift) begin
            for (int i = 1; i < int'(MAX_LEN); i++) begin
                seg_col[i] <= seg_col[i-1];
                seg_row[i] <= seg_row[i-1];
            end
            seg_col[0]   <= nxt_col;
            seg_row[0]   <= nxt_row;
            cur_dir      <= new_dir;
            grow_pending <= 1'b0;
            if (grows)
                length <= length + LW'(1);
        end else if (do_hit) begin
            grow_pending <= 1'b0;
        end else if (state_q == S_RUN && grow) begin
            grow_pending <= 1'b1;
        end
    end

    // Pixel-to-cell mapping: x/20 is the same as x[9:1]/10
    always_comb begin
        px_col      = 6'(pixel_x / 10'd20);
        px_row      = 6'(pixel_y / 10'd20);
        px_in_range = (pixel_x < 10'd640) && (pixel_y < 10'd480);
        px_match    = 1'b0;
        for (int i = 0; i < int'(MAX_LEN); i++) begin
            if ((LW'(i) < length) && ({1'b0, seg_col[i]} == px_col) && ({1'b0, seg_row[i]} == px_row))
                px_match = 1'b1;
        end
    end

    always_ff @(posedge clk_crystal) begin
        if (reset)
            snake_region <= 1'b0;
        else
            snake_region <= (state_q != S_IDLE) && px_in_range && px_match;
    end

endmodule

// File: tb/tb_snake_body_tracker.sv
// Bench for snake_body_tracker: directed scenarios plus random play against a queue-based model.
module tb_snake_body_tracker;

    logic       clk_crystal = 1'b0;
    logic       reset = 1'b1, start = 1'b0, step_tick = 1'b0, grow = 1'b0;
    logic [1:0] dir = 2'd3;
    logic [9:0] pixel_x = 10'd0, pixel_y = 10'd0;
    logic       snake_region, dead, hit_pulse;
    logic [4:0] head_col, head_row, length;

    int checks = 0;
    int failures = 0;

    snake_body_tracker dut (
        .clk_crystal (clk_crystal),
        .reset       (reset),
        .start       (start),
        .step_tick   (step_tick),
        .dir         (dir),
        .grow        (grow),
        .pixel_x     (pixel_x),
        .pixel_y     (pixel_y),
        .snake_region(snake_region),
        .head_col    (head_col),
        .head_row    (head_row),
        .length      (length),
        .dead        (dead),
        .hit_pulse   (hit_pulse)
    );

    always #5 clk_crystal = ~clk_crystal;

    // Model: body as a list of cells, state 0 idle / 1 run / 2 dead
    int m_col[$];
    int m_row[$];
    int m_dir, m_gp, m_state, m_hit, m_region;

    function automatic void m_init();
        m_col.delete();
        m_row.delete();
        for (int k = 0; k < 3; k++) begin
            m_col.push_back(10 - k);
            m_row.push_back(12);
        end
        m_dir = 3;
        m_gp  = 0;
    endfunction

    function automatic int m_in_body(int c, int r, int n);
        for (int k = 0; k < n; k++)
            if (m_col[k] == c && m_row[k] == r) return 1;
        return 0;
    endfunction

    function automatic int opposite(int d);
        case (d)
            0: return 1;
            1: return 0;
            2: return 3;
            default: return 2;
        endcase
    endfunction

    function automatic void m_region_calc();
        int c, r;
        c = (int'(pixel_x) / 2) / 10;
        r = (int'(pixel_y) / 2) / 10;
        m_region = (!reset && m_state != 0 && pixel_x < 640 && pixel_y < 480 &&
                    m_in_body(c, r, m_col.size()) != 0) ? 1 : 0;
    endfunction

    function automatic void m_update();
        int g, nd, nc, nr, len, wall, selfh, grows;
        m_hit = 0;
        if (reset) begin
            m_init();
            m_state = 0;
            return;
        end
        if (m_state != 1) begin
            if (start) begin
                m_init();
                m_state = 1;
            end
            return;
        end
        len   = m_col.size();
        g     = (m_gp != 0 || grow) ? 1 : 0;
        grows = (g != 0 && len < 16) ? 1 : 0;
        if (!step_tick) begin
            if (grow) m_gp = 1;
            return;
        end
        nd = (int'(dir) == opposite(m_dir)) ? m_dir : int'(dir);
        nc = m_col[0] + ((nd == 3) ? 1 : 0) - ((nd == 2) ? 1 : 0);
        nr = m_row[0] + ((nd == 1) ? 1 : 0) - ((nd == 0) ? 1 : 0);
        if (nc < 0) nc = 31;
        if (nc > 31) nc = 0;
        wall  = (nr == 0 || nr == 23 || ((nc == 0 || nc == 31) && nr != 12)) ? 1 : 0;
        selfh = m_in_body(nc, nr, grows ? len : len - 1);
        if (wall != 0 || selfh != 0) begin
            m_state = 2;
            m_hit   = 1;
        end else begin
            m_col.push_front(nc);
            m_row.push_front(nr);
            if (grows == 0) begin
                void'(m_col.pop_back());
                void'(m_row.pop_back());
            end
            m_dir = nd;
        end
        m_gp = 0;
    endfunction

    task automatic cyc(input logic st, input logic sp, input logic [1:0] d, input logic gr);
        start = st; step_tick = sp; dir = d; grow = gr;
        m_region_calc();
        @(posedge clk_crystal);
        m_update();
        #1;
        start = 1'b0; step_tick = 1'b0; grow = 1'b0;
    endtask

    task automatic set_cell(input int c, input int r);
        pixel_x = 10'(c * 20 + int'($urandom_range(0, 19)));
        pixel_y = 10'(r * 20 + int'($urandom_range(0, 19)));
    endtask

    task automatic do_reset_start();
        reset = 1'b1;
        cyc(1'b0, 1'b0, 2'd3, 1'b0);
        reset = 1'b0;
        cyc(1'b1, 1'b0, 2'd3, 1'b0);
    endtask

    task automatic test_reset();
        reset = 1'b1;
        cyc(1'b0, 1'b0, 2'd3, 1'b0);
        cyc(1'b1, 1'b1, 2'd0, 1'b1);
        reset = 1'b0;
        checks++; if (head_col !== 5'd10) begin failures++; $display("FAIL reset_head_col got=%0d exp=10", head_col); end
        checks++; if (head_row !== 5'd12) begin failures++; $display("FAIL reset_head_row got=%0d exp=12", head_row); end
        checks++; if (length !== 5'd3) begin failures++; $display("FAIL reset_length got=%0d exp=3", length); end
        checks++; if (dead !== 1'b0 || hit_pulse !== 1'b0) begin failures++; $display("FAIL reset_dead_hit got=%b%b exp=00", dead, hit_pulse); end
        checks++; if (snake_region !== 1'b0) begin failures++; $display("FAIL reset_region got=%b exp=0", snake_region); end
        set_cell(10, 12);
        cyc(1'b0, 1'b1, 2'd0, 1'b1);
        cyc(1'b0, 1'b0, 2'd0, 1'b0);
        checks++; if (head_row !== 5'd12 || length !== 5'd3) begin failures++; $display("FAIL idle_step_ignored got=(%0d,%0d) len=%0d exp=(10,12) len=3", head_col, head_row, length); end
        checks++; if (snake_region !== 1'b0) begin failures++; $display("FAIL idle_region got=%b exp=0", snake_region); end
    endtask

    task automatic test_region();
        int cells[6][3] = '{'{14,12,1}, '{13,12,1}, '{12,12,1}, '{11,12,0}, '{14,13,0}, '{7,12,0}};
        do_reset_start();
        set_cell(7, 12);
        cyc(1'b0, 1'b0, 2'd3, 1'b0);
        checks++; if (snake_region !== 1'b0) begin failures++; $display("FAIL stale_seg_region got=%b exp=0", snake_region); end
        repeat (4) cyc(1'b0, 1'b1, 2'd3, 1'b0);
        checks++; if (head_col !== 5'd14 || head_row !== 5'd12) begin failures++; $display("FAIL run4_head got=(%0d,%0d) exp=(14,12)", head_col, head_row); end
        checks++; if (length !== 5'd3) begin failures++; $display("FAIL run4_length got=%0d exp=3", length); end
        foreach (cells[k]) begin
            set_cell(cells[k][0], cells[k][1]);
            cyc(1'b0, 1'b0, 2'd3, 1'b0);
            checks++;
            if (snake_region !== 1'(cells[k][2]) || int'(snake_region) != m_region) begin
                failures++;
                $display("FAIL region_cell(%0d,%0d) got=%b exp=%0d", cells[k][0], cells[k][1], snake_region, cells[k][2]);
            end
        end
    endtask

    task automatic test_reversal();
        do_reset_start();
        repeat (2) cyc(1'b0, 1'b1, 2'd3, 1'b0);
        cyc(1'b0, 1'b1, 2'd2, 1'b0);
        checks++; if (head_col !== 5'd13 || head_row !== 5'd12) begin failures++; $display("FAIL reverse_rejected got=(%0d,%0d) exp=(13,12)", head_col, head_row); end
        cyc(1'b0, 1'b1, 2'd0, 1'b0);
        checks++; if (head_col !== 5'd13 || head_row !== 5'd11) begin failures++; $display("FAIL turn_up got=(%0d,%0d) exp=(13,11)", head_col, head_row); end
        cyc(1'b0, 1'b1, 2'd1, 1'b0);
        checks++; if (head_col !== 5'd13 || head_row !== 5'd10) begin failures++; $display("FAIL reverse_down got=(%0d,%0d) exp=(13,10)", head_col, head_row); end
    endtask

    task automatic test_tunnel_wall();
        do_reset_start();
        repeat (21) cyc(1'b0, 1'b1, 2'd3, 1'b0);
        checks++; if (head_col !== 5'd31 || dead !== 1'b0) begin failures++; $display("FAIL tunnel_enter got=col%0d dead=%b exp=col31 dead=0", head_col, dead); end
        cyc(1'b0, 1'b1, 2'd3, 1'b0);
        checks++; if (head_col !== 5'd0 || head_row !== 5'd12 || hit_pulse !== 1'b0 || dead !== 1'b0) begin failures++; $display("FAIL wrap_right got=(%0d,%0d) hit=%b exp=(0,12) hit=0", head_col, head_row, hit_pulse); end
        do_reset_start();
        cyc(1'b0, 1'b1, 2'd0, 1'b0);
        repeat (9) cyc(1'b0, 1'b1, 2'd2, 1'b0);
        cyc(1'b0, 1'b1, 2'd1, 1'b0);
        repeat (2) cyc(1'b0, 1'b1, 2'd2, 1'b0);
        checks++; if (head_col !== 5'd31 || head_row !== 5'd12 || dead !== 1'b0) begin failures++; $display("FAIL wrap_left got=(%0d,%0d) dead=%b exp=(31,12) dead=0", head_col, head_row, dead); end
        do_reset_start();
        repeat (11) cyc(1'b0, 1'b1, 2'd0, 1'b0);
        checks++; if (head_row !== 5'd1 || dead !== 1'b0) begin failures++; $display("FAIL up_to_row1 got=row%0d dead=%b exp=row1 dead=0", head_row, dead); end
        cyc(1'b0, 1'b1, 2'd0, 1'b0);
        checks++; if (hit_pulse !== 1'b1 || dead !== 1'b1) begin failures++; $display("FAIL wall_hit got=hit%b dead%b exp=hit1 dead1", hit_pulse, dead); end
        checks++; if (head_col !== 5'd10 || head_row !== 5'd1) begin failures++; $display("FAIL wall_frozen got=(%0d,%0d) exp=(10,1)", head_col, head_row); end
        set_cell(10, 1);
        cyc(1'b0, 1'b1, 2'd0, 1'b0);
        checks++; if (hit_pulse !== 1'b0 || dead !== 1'b1 || head_row !== 5'd1) begin failures++; $display("FAIL dead_hold got=hit%b dead%b row%0d exp=hit0 dead1 row1", hit_pulse, dead, head_row); end
        checks++; if (snake_region !== 1'b1) begin failures++; $display("FAIL dead_region got=%b exp=1", snake_region); end
    endtask

    task automatic test_grow();
        do_reset_start();
        cyc(1'b0, 1'b1, 2'd3, 1'b1);
        checks++; if (length !== 5'd4) begin failures++; $display("FAIL grow_same_step got=%0d exp=4", length); end
        cyc(1'b0, 1'b0, 2'd3, 1'b1);
        cyc(1'b0, 1'b0, 2'd3, 1'b1);
        cyc(1'b0, 1'b1, 2'd3, 1'b0);
        checks++; if (length !== 5'd5) begin failures++; $display("FAIL grow_multi_pulse got=%0d exp=5", length); end
        cyc(1'b0, 1'b1, 2'd3, 1'b0);
        checks++; if (length !== 5'd5) begin failures++; $display("FAIL grow_cleared got=%0d exp=5", length); end
        repeat (11) cyc(1'b0, 1'b1, 2'd3, 1'b1);
        checks++; if (length !== 5'd16 || head_col !== 5'd24) begin failures++; $display("FAIL grow_to_max got=len%0d col%0d exp=len16 col24", length, head_col); end
        cyc(1'b0, 1'b1, 2'd3, 1'b1);
        checks++; if (length !== 5'd16 || head_col !== 5'd25 || dead !== 1'b0) begin failures++; $display("FAIL grow_at_max got=len%0d col%0d exp=len16 col25", length, head_col); end
        cyc(1'b0, 1'b1, 2'd3, 1'b0);
        checks++; if (length !== 5'd16 || head_col !== 5'd26) begin failures++; $display("FAIL after_max got=len%0d col%0d exp=len16 col26", length, head_col); end
    endtask

    task automatic test_self_hit();
        do_reset_start();
        cyc(1'b0, 1'b1, 2'd3, 1'b1);
        cyc(1'b0, 1'b1, 2'd0, 1'b0);
        cyc(1'b0, 1'b1, 2'd2, 1'b0);
        cyc(1'b0, 1'b1, 2'd1, 1'b0);
        checks++; if (dead !== 1'b0 || head_col !== 5'd10 || head_row !== 5'd12 || length !== 5'd4) begin failures++; $display("FAIL tail_vacated got=(%0d,%0d) len%0d dead%b exp=(10,12) len4 dead0", head_col, head_row, length, dead); end
        do_reset_start();
        cyc(1'b0, 1'b1, 2'd3, 1'b1);
        cyc(1'b0, 1'b1, 2'd0, 1'b0);
        cyc(1'b0, 1'b1, 2'd2, 1'b0);
        cyc(1'b0, 1'b1, 2'd1, 1'b1);
        checks++; if (hit_pulse !== 1'b1 || dead !== 1'b1) begin failures++; $display("FAIL tail_grow_hit got=hit%b dead%b exp=hit1 dead1", hit_pulse, dead); end
        checks++; if (head_col !== 5'd10 || head_row !== 5'd11 || length !== 5'd4) begin failures++; $display("FAIL self_frozen got=(%0d,%0d) len%0d exp=(10,11) len4", head_col, head_row, length); end
    endtask

    task automatic test_reset_mid();
        do_reset_start();
        repeat (2) cyc(1'b0, 1'b1, 2'd3, 1'b0);
        reset = 1'b1;
        cyc(1'b0, 1'b1, 2'd0, 1'b1);
        reset = 1'b0;
        checks++; if (head_col !== 5'd10 || head_row !== 5'd12 || length !== 5'd3 || dead !== 1'b0) begin failures++; $display("FAIL mid_reset got=(%0d,%0d) len%0d exp=(10,12) len3", head_col, head_row, length); end
        set_cell(10, 12);
        cyc(1'b0, 1'b0, 2'd3, 1'b0);
        checks++; if (snake_region !== 1'b0) begin failures++; $display("FAIL mid_reset_region got=%b exp=0", snake_region); end
        cyc(1'b1, 1'b0, 2'd3, 1'b0);
        repeat (12) cyc(1'b0, 1'b1, 2'd0, 1'b0);
        checks++; if (dead !== 1'b1) begin failures++; $display("FAIL die_before_restart got=%b exp=1", dead); end
        cyc(1'b1, 1'b0, 2'd0, 1'b0);
        checks++; if (dead !== 1'b0 || head_col !== 5'd10 || head_row !== 5'd12 || length !== 5'd3) begin failures++; $display("FAIL restart got=(%0d,%0d) len%0d dead%b exp=(10,12) len3 dead0", head_col, head_row, length, dead); end
        set_cell(9, 12);
        cyc(1'b0, 1'b0, 2'd0, 1'b0);
        checks++; if (snake_region !== 1'b1) begin failures++; $display("FAIL restart_region got=%b exp=1", snake_region); end
    endtask

    task automatic test_random();
        int bad;
        do_reset_start();
        for (int n = 0; n < 3000; n++) begin
            reset = ($urandom_range(0, 199) == 0);
            if ($urandom_range(0, 1) == 0) begin
                pixel_x = 10'($urandom_range(0, 700));
                pixel_y = 10'($urandom_range(0, 520));
            end else begin
                int k;
                k = int'($urandom_range(0, m_col.size() - 1));
                set_cell(m_col[k], m_row[k]);
            end
            cyc(1'($urandom_range(0, 15) == 0), 1'($urandom_range(0, 2) == 0),
                2'($urandom_range(0, 3)), 1'($urandom_range(0, 5) == 0));
            bad = 0;
            if (head_col !== 5'(m_col[0]) || head_row !== 5'(m_row[0])) bad = 1;
            if (length !== 5'(m_col.size())) bad = 1;
            if (dead !== 1'(m_state == 2) || hit_pulse !== 1'(m_hit)) bad = 1;
            if (snake_region !== 1'(m_region)) bad = 1;
            checks++;
            if (bad != 0) begin
                failures++;
                $display("FAIL random_cycle%0d got=(%0d,%0d) len%0d dead%b hit%b reg%b exp=(%0d,%0d) len%0d dead%0d hit%0d reg%0d",
                         n, head_col, head_row, length, dead, hit_pulse, snake_region,
                         m_col[0], m_row[0], m_col.size(), (m_state == 2), m_hit, m_region);
            end
        end
        reset = 1'b0;
    endtask

    initial begin
        m_init();
        m_state = 0;
        m_hit = 0;
        m_region = 0;
        test_reset();
        test_region();
        test_reversal();
        test_tunnel_wall();
        test_grow();
        test_self_hit();
        test_reset_mid();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
